// File: rtl/chebyshev_pkg.sv
// Fixed-point format constants shared by the Chebyshev series evaluator.
package chebyshev_pkg;

    localparam int DEF_WL       = 4;
    localparam int DEF_CL       = 4;
    localparam int DEF_CF       = 2;
    localparam int DEF_WIDENING = 1;
    localparam int DEF_ORDER    = 3;

    localparam int OUT      = 2 * DEF_WL + DEF_CL + DEF_WIDENING;
    localparam int T_WL     = 2 * DEF_WL;
    localparam int T_FRAC   = 2 * DEF_WL - 2;
    localparam int OUT_FRAC = DEF_CF + 2 * DEF_WL - 2;

    localparam logic [T_WL-1:0] ONE_T = T_WL'(1) << T_FRAC;

endpackage

// File: rtl/chebyshev_recurrence.sv
// Chebyshev polynomial recurrence: holds x, T_{k-1} and T_k in Q2.(2WL-2).
module chebyshev_recurrence
    import chebyshev_pkg::*;
#(
    parameter int WL = DEF_WL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [WL-1:0]     x_in,
    output logic [2*WL-1:0]   t_cur
);

    localparam int TW = 2 * WL;
    localparam int PW = 3 * WL;
    localparam logic [TW-1:0] ONE = TW'(1) << (TW - 2);

    logic [WL-1:0] x_q, x_d;
    logic [TW-1:0] t_prev_q, t_prev_d;
    logic [TW-1:0] t_cur_q, t_cur_d;
    logic signed [PW-1:0] prod;

    always_comb begin
        prod     = PW'($signed(x_q)) * PW'($signed(t_cur_q));
        x_d      = x_q;
        t_prev_d = t_prev_q;
        t_cur_d  = t_cur_q;
        if (load) begin
            x_d      = x_in;
            t_prev_d = ONE;
            t_cur_d  = TW'($signed(x_in)) << (WL - 1);
        end else if (step) begin
            // x*T has 3WL-3 fraction bits; dropping WL-2 of them also doubles it
            t_prev_d = t_cur_q;
            t_cur_d  = TW'(prod >>> (WL - 2)) - t_prev_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q      <= '0;
            t_prev_q <= '0;
            t_cur_q  <= '0;
        end else begin
            x_q      <= x_d;
            t_prev_q <= t_prev_d;
            t_cur_q  <= t_cur_d;
        end
    end

    assign t_cur = t_cur_q;

endmodule

// File: rtl/chebyshev_computation_v2.sv
// Truncated Chebyshev series evaluator: one coefficient per clock, ORDER terms.
module chebyshev_computation_v2
    import chebyshev_pkg::*;
#(
    parameter int WL       = DEF_WL,
    parameter int CL       = DEF_CL,
    parameter int CF       = DEF_CF,
    parameter int WIDENING = DEF_WIDENING,
    parameter int ORDER    = DEF_ORDER
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WL-1:0]                data_in,
    input  logic [CL-1:0]                coeff_in,
    output logic [2*WL+CL+WIDENING-1:0]  data_out
);

    localparam int OW       = 2 * WL + CL + WIDENING;
    localparam int O_FRAC   = CF + 2 * WL - 2;
    localparam int KW       = $clog2(ORDER);
    localparam logic [KW-1:0] LAST = KW'(ORDER - 1);

    logic [KW-1:0] k_q, k_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] out_q, out_d;
    logic [2*WL-1:0] t_cur;
    logic [OW-1:0] term;
    logic first, last;

    assign first = (k_q == '0);
    assign last  = (k_q == LAST);

    chebyshev_recurrence #(
        .WL(WL)
    ) u_rec (
        .clock (clock),
        .reset (reset),
        .load  (first),
        .step  (!first && !last),
        .x_in  (data_in),
        .t_cur (t_cur)
    );

    always_comb begin
        term  = OW'($signed(coeff_in)) * OW'($signed(t_cur));
        acc_d = acc_q;
        out_d = out_q;
        k_d   = k_q + KW'(1);
        if (first) begin
            // c0*T0: align the coefficient to the output fraction point
            acc_d = OW'($signed(coeff_in)) << (O_FRAC - CF);
        end else if (last) begin
            out_d = acc_q + term;
            k_d   = '0;
        end else begin
            acc_d = acc_q + term;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k_q   <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            k_q   <= k_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign data_out = out_q;

endmodule

// File: tb/tb_chebyshev_computation_v2.sv
// Scoreboard bench for the Chebyshev series evaluator (default parameters).
module tb_chebyshev_computation_v2;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  data_in;
    logic [3:0]  coeff_in;
    logic [12:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] held;

    chebyshev_computation_v2 dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .coeff_in (coeff_in),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    function automatic int wrap(int v, int w);
        int m;
        m = 1 << w;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    // Reference: Q2.6 polynomials, result with 8 fraction bits
    function automatic logic [12:0] model(int x, int c0, int c1, int c2);
        int t0, t1, t2, acc;
        t0  = 64;
        t1  = x * 8;
        t2  = wrap(((x * t1) >>> 2) - t0, 8);
        acc = c0 * t0 + c1 * t1 + c2 * t2;
        return 13'(wrap(acc, 13));
    endfunction

    task automatic cycle(input logic [3:0] x, input logic [3:0] c);
        data_in  = x;
        coeff_in = c;
        @(posedge clock);
        #1;
    endtask

    task automatic run_eval(input string name, input logic [3:0] x,
                            input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] junk,
                            input logic [12:0] want);
        logic [3:0] cs [3];
        logic [12:0] e;
        cs[0] = c0;
        cs[1] = c1;
        cs[2] = c2;
        exp_q.push_back(want);
        for (int i = 0; i < 3; i++) begin
            cycle((i == 0) ? x : junk, cs[i]);
            checks++;
            if (i < 2) begin
                if (data_out !== held) begin
                    errors++;
                    $display("FAIL %s hold term%0d: got %0d want %0d",
                             name, i, $signed(data_out), $signed(held));
                end
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL %s result: got %0d want %0d",
                             name, $signed(data_out), $signed(e));
                end
                held = e;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        data_in  = 4'b0101;
        coeff_in = 4'b0011;
        @(posedge clock);
        #1;
        checks++;
        if (data_out !== 13'd0) begin
            errors++;
            $display("FAIL reset: got %0d want 0", $signed(data_out));
        end
        held  = 13'd0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_eval("x_half", 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 13'd192);
        run_eval("x_zero", 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0111, 13'd0);
        run_eval("x_neg1", 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 13'd256);
        run_eval("neg_coef", 4'b0100, 4'b1100, 4'b0010, 4'b0100, 4'b1111,
                 13'h1EC0);
    endtask

    task automatic test_back_to_back();
        run_eval("b2b_a", 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b1001, 13'd192);
        run_eval("b2b_b", 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0111, 13'd160);
    endtask

    task automatic test_mid_reset();
        cycle(4'b0111, 4'b0111);
        cycle(4'b0000, 4'b0111);
        checks++;
        if (data_out !== held) begin
            errors++;
            $display("FAIL abort hold: got %0d want %0d",
                     $signed(data_out), $signed(held));
        end
        reset = 1'b1;
        cycle(4'b0111, 4'b0111);
        checks++;
        if (data_out !== 13'd0) begin
            errors++;
            $display("FAIL abort reset: got %0d want 0", $signed(data_out));
        end
        held  = 13'd0;
        reset = 1'b0;
        run_eval("post_abort", 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0110,
                 13'd192);
    endtask

    task automatic test_random();
        logic [3:0] x, c0, c1, c2;
        for (int n = 0; n < 12; n++) begin
            x  = 4'($urandom_range(0, 15));
            c0 = 4'($urandom_range(0, 15));
            c1 = 4'($urandom_range(0, 15));
            c2 = 4'($urandom_range(0, 15));
            run_eval("rand", x, c0, c1, c2, 4'($urandom_range(0, 15)),
                     model(int'($signed(x)), int'($signed(c0)),
                           int'($signed(c1)), int'($signed(c2))));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mid_reset();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
